mac_engine: RTL and testbench
=============================

MAC_ENGINE -- requirements
Module: mac_engine

Interface
REQ-001 Parameter W, default 16: signed operand width of a and b.
REQ-002 Parameter N_MAX, default 64: maximum number of terms per job.
REQ-003 Parameter G, default 8: accumulator guard bits, with G >= clog2(N_MAX); accumulator width ACC_W = 2*W+G.
REQ-004 Parameter OUT_W, default 16, and parameter SHIFT, default 15: result = acc >>> SHIFT, narrowed to OUT_W signed bits.
REQ-005 Parameter SAT, default 1: 1 saturates out-of-range results, 0 wraps them (keeps the low OUT_W bits).
REQ-006 clk, input, 1: single clock; all state updates on the rising edge.
REQ-007 clear_n, input, 1: asynchronous, active-low reset.
REQ-008 start, input, 1: begins a job; sampled only in IDLE.
REQ-009 len, input, clog2(N_MAX+1): term count, latched on an accepted start.
REQ-010 busy, output, 1: high in every state except IDLE.
REQ-011 a and b, inputs, W each: signed operand pair.
REQ-012 in_valid input and in_ready output, 1 each: operand handshake.
REQ-013 out_data, output, OUT_W: signed result.
REQ-014 out_valid output and out_ready input, 1 each: result handshake.
REQ-015 overflow, output, 1: the current result was saturated (SAT=1) or wrapped (SAT=0).

Function
REQ-016 The state machine SHALL have states IDLE, RUN, DRAIN and HOLD.
REQ-017 IDLE: start=1 with 1 <= len <= N_MAX latches len, clears the term counter and moves to RUN. start with len=0 or len>N_MAX SHALL be ignored, and the block stays in IDLE.
REQ-018 RUN: in_ready SHALL equal 1 while accepted terms < len. A term is accepted on any edge with in_valid && in_ready. Gaps in in_valid SHALL be tolerated with no effect.
REQ-019 An accepted term SHALL register prod = a*b (2W bits, signed, full precision) one edge after acceptance. The next edge SHALL update the accumulator.
REQ-020 The first product of a job SHALL load the accumulator, not add to it. Later products SHALL add, sign-extended to ACC_W. No residue from a prior job is permitted.
REQ-021 On acceptance of term len, the machine SHALL move to DRAIN, and in_ready SHALL deassert on that same edge.
REQ-022 Timing: last term accepted at edge k -> product at k, accumulator final at k+1, out_data/overflow/out_valid registered at k+2, and the state becomes HOLD.
REQ-023 Narrowing: r = acc >>> SHIFT (arithmetic shift, truncation toward -infinity).
- If r lies within [-2^(OUT_W-1), 2^(OUT_W-1)-1]: out_data = r and overflow = 0.
- Otherwise with SAT=1: clamp to the nearer bound, overflow = 1.
- Otherwise with SAT=0: keep the low OUT_W bits, overflow = 1.
REQ-024 HOLD: out_valid=1, with out_data and overflow stable, until out_valid && out_ready. That edge returns the machine to IDLE and clears out_valid and busy.
REQ-025 start in any state other than IDLE SHALL be ignored, including the HOLD handshake edge. The next job can start no earlier than the following cycle.
REQ-026 in_ready SHALL be 0 in IDLE, DRAIN and HOLD, and a and b SHALL be ignored in those states.
REQ-027 Products of -2^(W-1) * -2^(W-1) SHALL be represented exactly, with no internal overflow for any len <= N_MAX.

Reset
REQ-028 While clear_n=0, the block SHALL immediately be in IDLE with:
- busy=0, in_ready=0, out_valid=0, overflow=0, out_data=0;
- accumulator, product register and term counter all zero.
REQ-029 clear_n asserted mid-job SHALL abort the job with no output produced. The first start after release SHALL behave as on a fresh device.

Verification (W=16, OUT_W=16, SHIFT=15, N_MAX=64)
REQ-030 Basic job: len=3, a = 1000, -2000, 3000, b = 16384 each, in_valid continuous, out_ready=1 -> out_data=1000, overflow=0, out_valid rises 2 edges after the last acceptance and lasts 1 cycle.
REQ-031 Saturation (SAT=1): len=4, a=b=16384 -> out_data=32767, overflow=1. Same stimulus with SAT=0 -> out_data=-32768, overflow=1.
REQ-032 Negative extreme: len=2, a=b=-32768 -> acc=2^31, r=65536 -> out_data=32767 (SAT=1), overflow=1.
REQ-033 Flow control:
- in_valid toggled 1,0,0,1,0,1 for len=3 -> same result as the continuous-input case.
- out_ready held low 5 cycles -> out_data and out_valid stable.
- start pulsed during RUN and HOLD -> ignored.
REQ-034 Boundary: start with len=0 -> busy stays 0. Two back-to-back jobs (len=1, a=2, b=16384, then a=4, b=16384) -> results 1 then 2, proving the accumulator is reloaded per job.
REQ-035 Reset: clear_n pulsed low after 2 of 5 terms -> all outputs 0 immediately. A new len=1 job with a=b=16384 then yields 8192.

Source files
------------

// File: rtl/mac_engine.sv
`default_nettype none
// ============================================================================
// mac_engine : signed multiply-accumulate job engine, narrowed/saturated output
// Revision   : 1.0 - initial release
// ============================================================================
module mac_engine #(
  parameter int W     = 16,
  parameter int N_MAX = 64,
  parameter int G     = 8,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int SAT   = 1,
  localparam int LEN_W = $clog2(N_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    clear_n,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  output logic                    busy,
  input  logic signed [W-1:0]     a,
  input  logic signed [W-1:0]     b,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow
);

  localparam int c_acc_w = 2 * W + G;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;
  localparam logic [1:0] c_st_hold  = 2'd3;

  localparam logic [LEN_W-1:0] c_len_max = LEN_W'(N_MAX);

  logic [1:0]                r_state;
  logic [1:0]                w_next_state;
  logic [LEN_W-1:0]          r_len;
  logic [LEN_W-1:0]          r_cnt;
  logic signed [2*W-1:0]     r_prod;
  logic                      r_prod_vld;
  logic                      r_first;
  logic signed [c_acc_w-1:0] r_acc;
  logic signed [OUT_W-1:0]   r_out_data;
  logic                      r_overflow;
  logic                      r_out_valid;

  logic                      w_start_ok;
  logic                      w_start_go;
  logic                      w_accept;
  logic                      w_last;
  logic                      w_load_out;
  logic                      w_out_fire;
  logic signed [2*W-1:0]     w_a_ext;
  logic signed [2*W-1:0]     w_b_ext;
  logic signed [2*W-1:0]     w_prod;
  logic signed [c_acc_w-1:0] w_prod_ext;
  logic signed [c_acc_w-1:0] w_shifted;
  logic [c_acc_w-OUT_W:0]    w_hi;
  logic                      w_in_range;
  logic signed [OUT_W-1:0]   w_narrow;
  logic                      w_ovf;

  assign w_start_ok = start && (len != '0) && (len <= c_len_max);
  assign w_start_go = w_start_ok && (r_state == c_st_idle);
  assign w_accept   = in_valid && in_ready;
  assign w_last     = ((r_cnt + LEN_W'(1)) == r_len);
  // DRAIN's second edge: the final product has already been folded into r_acc
  assign w_load_out = (r_state == c_st_drain) && !r_prod_vld;
  assign w_out_fire = (r_state == c_st_hold) && r_out_valid && out_ready;

  // Operands widened to 2W first so the product is exact, including -2^(W-1)^2
  assign w_a_ext    = {{W{a[W-1]}}, a};
  assign w_b_ext    = {{W{b[W-1]}}, b};
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_prod_ext = {{G{r_prod[2*W-1]}}, r_prod};

  assign w_shifted  = r_acc >>> SHIFT;
  assign w_hi       = w_shifted[c_acc_w-1:OUT_W-1];
  assign w_in_range = (&w_hi) || !(|w_hi);

  always_comb begin
    w_narrow = w_shifted[OUT_W-1:0];
    w_ovf    = 1'b0;
    if (!w_in_range) begin
      w_ovf = 1'b1;
      if (SAT != 0) begin
        w_narrow = w_shifted[c_acc_w-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                        : {1'b0, {(OUT_W-1){1'b1}}};
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle:  if (w_start_ok)          w_next_state = c_st_run;
      c_st_run:   if (w_accept && w_last)  w_next_state = c_st_drain;
      c_st_drain: if (!r_prod_vld)         w_next_state = c_st_hold;
      c_st_hold:  if (w_out_fire)          w_next_state = c_st_idle;
      default:                             w_next_state = c_st_idle;
    endcase
  end

  always_comb begin
    busy     = (r_state != c_st_idle);
    in_ready = (r_state == c_st_run) && (r_cnt < r_len);
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_len       <= '0;
      r_cnt       <= '0;
      r_prod      <= '0;
      r_prod_vld  <= 1'b0;
      r_first     <= 1'b0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_start_go) begin
        r_len   <= len;
        r_cnt   <= '0;
        r_first <= 1'b1;
      end
      if (w_accept) begin
        r_prod <= w_prod;
        r_cnt  <= r_cnt + LEN_W'(1);
      end
      r_prod_vld <= w_accept;
      // First product of a job overwrites whatever the previous job left behind
      if (r_prod_vld) begin
        r_acc   <= r_first ? w_prod_ext : (r_acc + w_prod_ext);
        r_first <= 1'b0;
      end
      if (w_load_out) begin
        r_out_data  <= w_narrow;
        r_overflow  <= w_ovf;
        r_out_valid <= 1'b1;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign overflow  = r_overflow;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_mac_engine.sv
`default_nettype none
// ============================================================================
// tb_mac_engine : directed vector bench for mac_engine (SAT=1 and SAT=0 copies)
// Revision      : 1.0 - initial release
// ============================================================================
module tb_mac_engine;

  logic               clk = 1'b0;
  logic               clear_n = 1'b0;
  logic               start = 1'b0;
  logic [6:0]         len = '0;
  logic signed [15:0] a = '0;
  logic signed [15:0] b = '0;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b1;

  logic               busy_s, in_ready_s, out_valid_s, overflow_s;
  logic signed [15:0] out_s;
  logic               busy_w, in_ready_w, out_valid_w, overflow_w;
  logic signed [15:0] out_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_engine #(.W(16), .N_MAX(64), .G(8), .OUT_W(16), .SHIFT(15), .SAT(1)) dut_s (
    .clk(clk), .clear_n(clear_n), .start(start), .len(len), .busy(busy_s),
    .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready_s),
    .out_data(out_s), .out_valid(out_valid_s), .out_ready(out_ready),
    .overflow(overflow_s)
  );

  mac_engine #(.W(16), .N_MAX(64), .G(8), .OUT_W(16), .SHIFT(15), .SAT(0)) dut_w (
    .clk(clk), .clear_n(clear_n), .start(start), .len(len), .busy(busy_w),
    .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready_w),
    .out_data(out_w), .out_valid(out_valid_w), .out_ready(out_ready),
    .overflow(overflow_w)
  );

  typedef struct packed {
    int              len;
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    logic [15:0]     vmask;
    int              hold;
    logic            poke;
    int              exp_s;
    logic            ovf_s;
    int              exp_w;
    logic            ovf_w;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int n, input int a0, input int a1, input int a2,
                              input int a3, input int b0, input int b1, input int b2,
                              input int b3, input logic [15:0] vm, input int hold,
                              input logic poke, input int es, input logic os,
                              input int ew, input logic ow);
    vec_t v;
    v.len   = n;
    v.a[0]  = 16'(a0); v.a[1] = 16'(a1); v.a[2] = 16'(a2); v.a[3] = 16'(a3);
    v.b[0]  = 16'(b0); v.b[1] = 16'(b1); v.b[2] = 16'(b2); v.b[3] = 16'(b3);
    v.vmask = vm;
    v.hold  = hold;
    v.poke  = poke;
    v.exp_s = es;
    v.ovf_s = os;
    v.exp_w = ew;
    v.ovf_w = ow;
    return v;
  endfunction

  // Term i uses operand slot i%4; vmask bit (cycle%16) gates in_valid
  task automatic run_vec(input string tag, input vec_t v);
    int  acc_i;
    int  cyc;
    int  lat;
    bit  acc_now;
    acc_i = 0;
    cyc   = 0;
    @(negedge clk);
    start = 1'b1;
    len   = 7'(v.len);
    @(negedge clk);
    start = v.poke;
    len   = 7'd1;
    chk({tag, " busy_after_start"}, int'(busy_s), 1);
    out_ready = (v.hold == 0);
    while (acc_i < v.len && cyc < 400) begin
      in_valid = v.vmask[cyc % 16];
      if (in_valid) begin
        a = v.a[acc_i % 4];
        b = v.b[acc_i % 4];
      end else begin
        a = 16'sh7fff;
        b = 16'sh7fff;
      end
      acc_now = in_valid && in_ready_s;
      cyc++;
      @(negedge clk);
      if (acc_now) acc_i++;
    end
    in_valid = 1'b0;
    a        = 16'sh1234;
    b        = 16'sh1234;
    start    = 1'b0;
    if (cyc >= 400) chk({tag, " feed_timeout"}, acc_i, v.len);
    chk({tag, " in_ready_drop"}, int'(in_ready_s), 0);
    lat = 0;
    while (!out_valid_s && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " out_latency"}, lat, 2);
    chk({tag, " data_sat"}, int'(out_s), v.exp_s);
    chk({tag, " ovf_sat"}, int'(overflow_s), int'(v.ovf_s));
    chk({tag, " data_wrap"}, int'(out_w), v.exp_w);
    chk({tag, " ovf_wrap"}, int'(overflow_w), int'(v.ovf_w));
    if (v.poke) begin
      start = 1'b1;
      len   = 7'd1;
    end
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk({tag, " hold_stable"},
          int'(out_valid_s && busy_s && (int'(out_s) == v.exp_s)), 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, " released"}, int'(out_valid_s || busy_s || busy_w), 0);
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(3, 1000, -2000, 3000, 0, 16384, 16384, 16384, 16384,
                  16'hFFFF, 0, 1'b0, 1000, 1'b0, 1000, 1'b0);
    vecs[1]  = mk(3, 1000, -2000, 3000, 0, 16384, 16384, 16384, 16384,
                  16'h0029, 5, 1'b1, 1000, 1'b0, 1000, 1'b0);
    vecs[2]  = mk(4, 16384, 16384, 16384, 16384, 16384, 16384, 16384, 16384,
                  16'hFFFF, 0, 1'b0, 32767, 1'b1, -32768, 1'b1);
    vecs[3]  = mk(2, -32768, -32768, 0, 0, -32768, -32768, 0, 0,
                  16'hFFFF, 0, 1'b0, 32767, 1'b1, 0, 1'b1);
    vecs[4]  = mk(64, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768,
                  16'hFFFF, 0, 1'b0, 32767, 1'b1, 0, 1'b1);
    vecs[5]  = mk(1, 2, 0, 0, 0, 16384, 0, 0, 0,
                  16'hFFFF, 0, 1'b0, 1, 1'b0, 1, 1'b0);
    vecs[6]  = mk(1, 4, 0, 0, 0, 16384, 0, 0, 0,
                  16'hFFFF, 0, 1'b0, 2, 1'b0, 2, 1'b0);
    vecs[7]  = mk(1, -1, 0, 0, 0, 1, 0, 0, 0,
                  16'hFFFF, 0, 1'b0, -1, 1'b0, -1, 1'b0);
    vecs[8]  = mk(2, -32768, -32768, 0, 0, 16384, 16384, 0, 0,
                  16'hFFFF, 0, 1'b0, -32768, 1'b0, -32768, 1'b0);
    vecs[9]  = mk(2, 32767, 32767, 0, 0, 16384, 16384, 0, 0,
                  16'hFFFF, 0, 1'b0, 32767, 1'b0, 32767, 1'b0);
    vecs[10] = mk(2, -32768, -32768, 0, 0, 32767, 32767, 0, 0,
                  16'hFFFF, 0, 1'b0, -32768, 1'b1, 2, 1'b1);

    // Reset state, observed while clear_n is still low
    #2;
    chk("rst busy", int'(busy_s), 0);
    chk("rst in_ready", int'(in_ready_s), 0);
    chk("rst out_valid", int'(out_valid_s), 0);
    chk("rst overflow", int'(overflow_s), 0);
    chk("rst out_data", int'(out_s), 0);
    @(negedge clk);
    clear_n = 1'b1;
    @(negedge clk);
    chk("idle in_ready", int'(in_ready_s), 0);

    for (int i = 0; i < NV; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Illegal lengths are ignored
    @(negedge clk);
    start = 1'b1;
    len   = 7'd0;
    @(negedge clk);
    start = 1'b0;
    chk("len0 busy", int'(busy_s), 0);
    start = 1'b1;
    len   = 7'd65;
    @(negedge clk);
    start = 1'b0;
    chk("len65 busy", int'(busy_s), 0);
    @(negedge clk);
    chk("len65 busy later", int'(busy_s), 0);

    // Abort mid-job: 2 of 5 terms, then asynchronous clear
    start = 1'b1;
    len   = 7'd5;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    a        = 16'sd16384;
    b        = 16'sd16384;
    repeat (2) @(negedge clk);
    chk("abort mid busy", int'(busy_s), 1);
    #2;
    clear_n = 1'b0;
    #1;
    chk("abort busy", int'(busy_s), 0);
    chk("abort in_ready", int'(in_ready_s), 0);
    chk("abort out_valid", int'(out_valid_s), 0);
    chk("abort overflow", int'(overflow_s), 0);
    chk("abort out_data", int'(out_s), 0);
    in_valid = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
    run_vec("post_abort", mk(1, 16384, 0, 0, 0, 16384, 0, 0, 0,
                             16'hFFFF, 0, 1'b0, 8192, 1'b0, 8192, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
